instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the control unit: owns the PC register, fetches

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
// A transfer completes in any cycle where InsMemReq and InsMemAck are both high; the
// master holds InsMemReq and InsMemAddr steady until that cycle, and InsMemData is
// valid only in it.
interface instruction_fetch_unit_if;
  logic        InsMemReq;
  logic [31:0] InsMemAddr;
  logic        InsMemAck;
  logic [31:0] InsMemData;

  modport master (
    output InsMemReq,
    output InsMemAddr,
    input  InsMemAck,
    input  InsMemData
  );

  modport slave (
    input  InsMemReq,
    input  InsMemAddr,
    output InsMemAck,
    output InsMemData
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction over the req/ack bus,
// presents it to the decoder for one EXEC cycle, then commits the decoder's next-PC choice.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [1:0]                    PCSrc,
  input  logic [31:0]                   Immediate,
  input  logic [25:0]                   JumpAddr,
  instruction_fetch_unit_if.master      insMem,
  output logic [31:0]                   Instruction,
  output logic                          InsValid,
  output logic [31:0]                   PC,
  output logic [31:0]                   PC4,
  output logic                          Halted,
  output logic                          FetchErr,
  output logic [1:0]                    dbgState
);

  localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } stateT;

  stateT            state, stateNext;
  logic [31:0]      pcQ, pcNext;
  logic [31:0]      instrQ, instrNext;
  logic [CNT_W-1:0] waitCnt, waitNext;
  logic             errQ, errNext;
  logic             reqRaw;
  logic             validRaw;
  logic             haltedRaw;
  logic [31:0]      pcSeq;

  assign pcSeq = pcQ + 32'd4;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= FETCH;
      pcQ     <= {RESET_PC[31:2], 2'b00};
      instrQ  <= 32'd0;
      waitCnt <= '0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      pcQ     <= pcNext;
      instrQ  <= instrNext;
      waitCnt <= waitNext;
      errQ    <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pcQ;
    instrNext = instrQ;
    waitNext  = waitCnt;
    errNext   = errQ;
    reqRaw    = 1'b0;
    validRaw  = 1'b0;
    haltedRaw = 1'b0;
    case (state)
      FETCH: begin
        reqRaw = 1'b1;
        // An ack in the final allowed cycle still wins over the timeout.
        if (insMem.InsMemAck) begin
          instrNext = insMem.InsMemData;
          waitNext  = '0;
          stateNext = EXEC;
        end else if (waitCnt == CNT_LAST) begin
          errNext   = 1'b1;
          waitNext  = '0;
          stateNext = HALTED;
        end else begin
          waitNext = waitCnt + CNT_W'(1);
        end
      end
      EXEC: begin
        validRaw  = 1'b1;
        stateNext = FETCH;
        case (PCSrc)
          2'b00: pcNext = pcSeq;
          2'b01: pcNext = pcSeq + (Immediate << 2);
          2'b10: pcNext = {pcSeq[31:28], JumpAddr, 2'b00};
          default: stateNext = HALTED;
        endcase
      end
      HALTED: begin
        haltedRaw = 1'b1;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Gating with Reset drops the request the moment reset asserts, abandoning any fetch.
  assign insMem.InsMemReq  = reqRaw & Reset;
  assign insMem.InsMemAddr = pcQ;
  assign Instruction       = instrQ;
  assign InsValid          = validRaw;
  assign PC                = pcQ;
  assign PC4               = pcSeq;
  assign Halted            = haltedRaw;
  assign FetchErr          = errQ;
  assign dbgState          = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: randomized memory latency and next-PC
// selects checked against a transaction-level PC/instruction model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          FETCH_TIMEOUT = 16;

  logic        CLK;
  logic        Reset;
  logic [1:0]  PCSrc;
  logic [31:0] Immediate;
  logic [25:0] JumpAddr;
  logic [31:0] Instruction;
  logic        InsValid;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Halted;
  logic        FetchErr;
  logic [1:0]  dbgState;

  instruction_fetch_unit_if memBus ();

  instruction_fetch_unit #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .PCSrc       (PCSrc),
    .Immediate   (Immediate),
    .JumpAddr    (JumpAddr),
    .insMem      (memBus.master),
    .Instruction (Instruction),
    .InsValid    (InsValid),
    .PC          (PC),
    .PC4         (PC4),
    .Halted      (Halted),
    .FetchErr    (FetchErr),
    .dbgState    (dbgState)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          numVectors     = 0;
  int          numMiscompares = 0;
  logic [31:0] expPc;
  logic        expErr;
  logic [31:0] expQ[$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numVectors++;
    if (obs !== exp) begin
      numMiscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference next-PC computed from the architectural rules.
  function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [1:0] src,
                                          input logic [31:0] imm, input logic [25:0] j);
    logic [31:0] seq;
    seq = pc + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return seq + imm * 32'd4;
      2'd2:    return (seq & 32'hF000_0000) + ({6'd0, j} * 32'd4);
      default: return pc;
    endcase
  endfunction

  // Word offset that makes a relative jump from the current expected PC land on target.
  function automatic logic [31:0] relImm(input logic [31:0] target);
    logic [31:0] diff;
    diff = target - (expPc + 32'd4);
    return {{2{diff[31]}}, diff[31:2]};
  endfunction

  // Driver tasks: all entered and left in the low clock phase.
  task automatic doReset();
    Reset = 1'b0;
    #1;
    checkVal("rstReq",   {31'd0, memBus.InsMemReq}, 32'd0);
    checkVal("rstPc",    PC, RESET_PC);
    checkVal("rstValid", {31'd0, InsValid}, 32'd0);
    checkVal("rstHalt",  {31'd0, Halted}, 32'd0);
    checkVal("rstErr",   {31'd0, FetchErr}, 32'd0);
    checkVal("rstInstr", Instruction, 32'd0);
    memBus.InsMemAck = 1'b0;
    repeat (2) @(negedge CLK);
    Reset  = 1'b1;
    expPc  = RESET_PC;
    expErr = 1'b0;
    #1;
  endtask

  task automatic doInstr(input int ackDelay, input logic [1:0] src, input logic [31:0] imm,
                         input logic [25:0] jaddr, input logic [31:0] data);
    for (int i = 0; i <= ackDelay; i++) begin
      checkVal("fetchReq",   {31'd0, memBus.InsMemReq}, 32'd1);
      checkVal("fetchAddr",  memBus.InsMemAddr, expPc);
      checkVal("fetchValid", {31'd0, InsValid}, 32'd0);
      PCSrc     = 2'($urandom_range(0, 3));
      Immediate = $urandom;
      JumpAddr  = 26'($urandom);
      if (i == ackDelay) begin
        memBus.InsMemAck  = 1'b1;
        memBus.InsMemData = data;
        expQ.push_back(data);
      end else begin
        memBus.InsMemAck  = 1'b0;
        memBus.InsMemData = $urandom;
      end
      @(negedge CLK);
    end
    checkVal("execValid", {31'd0, InsValid}, 32'd1);
    checkVal("execInstr", Instruction, expQ.pop_front());
    checkVal("execPc",    PC, expPc);
    checkVal("execPc4",   PC4, expPc + 32'd4);
    checkVal("execReq",   {31'd0, memBus.InsMemReq}, 32'd0);
    checkVal("execErr",   {31'd0, FetchErr}, {31'd0, expErr});
    memBus.InsMemAck  = 1'($urandom_range(0, 1));
    memBus.InsMemData = $urandom;
    PCSrc     = src;
    Immediate = imm;
    JumpAddr  = jaddr;
    @(negedge CLK);
    memBus.InsMemAck = 1'b0;
    expPc = refNext(expPc, src, imm, jaddr);
    checkVal("postHalt", {31'd0, Halted}, (src == 2'd3) ? 32'd1 : 32'd0);
    checkVal("postPc",   PC, expPc);
  endtask

  task automatic fetchStall(input int n);
    for (int i = 0; i < n; i++) begin
      checkVal("stallReq",  {31'd0, memBus.InsMemReq}, 32'd1);
      checkVal("stallAddr", memBus.InsMemAddr, expPc);
      checkVal("stallHalt", {31'd0, Halted}, 32'd0);
      memBus.InsMemAck  = 1'b0;
      memBus.InsMemData = $urandom;
      PCSrc = 2'($urandom_range(0, 3));
      @(negedge CLK);
    end
  endtask

  task automatic haltHold(input int n);
    for (int i = 0; i < n; i++) begin
      checkVal("holdHalt",  {31'd0, Halted}, 32'd1);
      checkVal("holdPc",    PC, expPc);
      checkVal("holdReq",   {31'd0, memBus.InsMemReq}, 32'd0);
      checkVal("holdValid", {31'd0, InsValid}, 32'd0);
      checkVal("holdErr",   {31'd0, FetchErr}, {31'd0, expErr});
      memBus.InsMemAck  = 1'($urandom_range(0, 1));
      memBus.InsMemData = $urandom;
      PCSrc = 2'($urandom_range(0, 3));
      @(negedge CLK);
    end
    memBus.InsMemAck = 1'b0;
  endtask

  // Stimulus
  initial begin
    Reset             = 1'b1;
    PCSrc             = 2'd0;
    Immediate         = 32'd0;
    JumpAddr          = 26'd0;
    memBus.InsMemAck  = 1'b0;
    memBus.InsMemData = 32'd0;
    expPc             = RESET_PC;
    expErr            = 1'b0;
    #2;
    doReset();

    // Zero-wait fetch, sequential next PC
    doInstr(0, 2'd0, 32'd0, 26'd0, 32'h2001_0005);
    checkVal("seqPc", PC, 32'h4);

    // Relative jumps backwards and forwards
    doInstr($urandom_range(0, 3), 2'd2, $urandom, 26'h10, $urandom);
    checkVal("jmp40", PC, 32'h40);
    doInstr(0, 2'd1, 32'hFFFF_FFFE, 26'($urandom), $urandom);
    checkVal("relBack", PC, 32'h3C);
    doInstr($urandom_range(0, 3), 2'd2, $urandom, 26'h10, $urandom);
    doInstr(1, 2'd1, 32'd3, 26'($urandom), $urandom);
    checkVal("relFwd", PC, 32'h50);

    // Absolute jump keeps the upper nibble; sequential wrap at the top of memory
    doInstr($urandom_range(0, 3), 2'd1, relImm(32'h1000_0010), 26'($urandom), $urandom);
    checkVal("at10000010", PC, 32'h1000_0010);
    doInstr(0, 2'd2, $urandom, 26'h000_0040, $urandom);
    checkVal("absJmp", PC, 32'h1000_0100);
    doInstr($urandom_range(0, 3), 2'd1, relImm(32'hFFFF_FFFC), 26'($urandom), $urandom);
    checkVal("atTop", PC, 32'hFFFF_FFFC);
    doInstr(0, 2'd0, $urandom, 26'($urandom), $urandom);
    checkVal("wrapPc", PC, 32'h0);

    // Slow memory
    doInstr(5, 2'd0, $urandom, 26'($urandom), $urandom);
    checkVal("slowErr", {31'd0, FetchErr}, 32'd0);

    // Random traffic
    repeat (80) begin
      doInstr($urandom_range(0, 6), 2'($urandom_range(0, 2)), $urandom, 26'($urandom), $urandom);
    end

    // Fetch timeout: no ack for FETCH_TIMEOUT cycles
    doReset();
    fetchStall(FETCH_TIMEOUT);
    checkVal("toHalt", {31'd0, Halted}, 32'd1);
    checkVal("toErr",  {31'd0, FetchErr}, 32'd1);
    checkVal("toReq",  {31'd0, memBus.InsMemReq}, 32'd0);
    expErr = 1'b1;
    haltHold(5);

    // Ack in the last allowed cycle is a normal fetch
    doReset();
    doInstr(FETCH_TIMEOUT - 1, 2'd0, $urandom, 26'($urandom), $urandom);
    checkVal("lateAckErr", {31'd0, FetchErr}, 32'd0);

    // Clean halt, frozen for a long stretch with stray acks
    doInstr($urandom_range(0, 3), 2'd2, $urandom, 26'h123, $urandom);
    doInstr($urandom_range(0, 3), 2'd3, $urandom, 26'($urandom), $urandom);
    checkVal("haltPc", PC, 32'h0000_048C);
    haltHold(25);

    // Reset while halted, restart from RESET_PC
    doReset();
    doInstr(2, 2'd0, $urandom, 26'($urandom), $urandom);
    checkVal("restartPc", PC, RESET_PC + 32'd4);

    // Reset in the middle of a fetch
    doInstr(0, 2'd2, $urandom, 26'h3F0, $urandom);
    fetchStall(3);
    doReset();
    doInstr(0, 2'd0, $urandom, 26'($urandom), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
